// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's redirect, instruction-memory and decode-side signals.
// The master modport is the fetch stage itself; slave is the surrounding pipeline and memory.
interface instr_fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_ready;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic [15:0] exception_out;

  modport master (
    input  redirect_valid, redirect_pc, out_ready,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output imem_req_valid, imem_req_addr,
    output out_valid, pc_out, instr_out, exception_out
  );

  modport slave (
    output redirect_valid, redirect_pc, out_ready,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, pc_out, instr_out, exception_out
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one memory request in flight,
// and holds {pc, instr, exception} toward decode until accepted or redirected.
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic        r_out_valid;
  logic [63:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic [15:0] r_exc_out;
  logic        w_req_valid;
  logic        w_misaligned;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // A redirect withdraws the request in the same cycle so a stale PC is never accepted.
  assign w_req_valid  = (r_state == S_REQ) && !bus.redirect_valid && !w_misaligned;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.out_valid      = r_out_valid;
  assign bus.pc_out         = r_pc_out;
  assign bus.instr_out      = r_instr_out;
  assign bus.exception_out  = r_exc_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_pc_out    <= 64'd0;
      r_instr_out <= 32'd0;
      r_exc_out   <= 16'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
          end else if (w_misaligned) begin
            r_pc_out    <= r_pc;
            r_instr_out <= NOP_INSTR;
            r_exc_out   <= 16'h0001;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (bus.imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            // A response landing with the redirect retires the old request outright.
            r_state <= bus.imem_resp_valid ? S_REQ : S_DROP;
          end else if (bus.imem_resp_valid) begin
            r_pc_out    <= r_pc;
            r_out_valid <= 1'b1;
            r_instr_out <= bus.imem_resp_err ? NOP_INSTR : bus.imem_resp_data;
            r_exc_out   <= bus.imem_resp_err ? 16'h0002 : 16'h0000;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            r_pc        <= bus.redirect_pc;
            r_out_valid <= 1'b0;
            r_state     <= S_REQ;
          end else if (bus.out_ready) begin
            r_pc        <= r_pc + 64'd4;
            r_out_valid <= 1'b0;
            r_state     <= S_REQ;
          end
        end
        default: begin
          if (bus.redirect_valid) r_pc <= bus.redirect_pc;
          if (bus.imem_resp_valid) r_state <= S_REQ;
        end
      endcase
    end
  end

  // Responses are only legal while a request is outstanding or being drained.
  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && (r_state == S_REQ || r_state == S_HOLD)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch: each row drives one cycle of inputs and
// lists the outputs expected during that cycle, before the next rising edge.
module tb_instr_fetch;
  localparam logic [63:0] A = 64'h0000_0000_8000_0000;

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        ordy;
    logic        qrdy;
    logic        rsv;
    logic [31:0] rdata;
    logic        rerr;
    logic        e_qv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic [15:0] e_exc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rv, input logic [63:0] rpc, input logic ordy, input logic qrdy,
    input logic rsv, input logic [31:0] rdata, input logic rerr,
    input logic e_qv, input logic [63:0] e_addr, input logic e_ov,
    input logic [63:0] e_pc, input logic [31:0] e_instr, input logic [15:0] e_exc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ordy = ordy; v.qrdy = qrdy;
    v.rsv = rsv; v.rdata = rdata; v.rerr = rerr;
    v.e_qv = e_qv; v.e_addr = e_addr; v.e_ov = e_ov;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 64'd0;
    bus.out_ready       = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'd0;
    bus.imem_resp_err   = 1'b0;
  endtask

  task automatic apply_row(input vec_t v, input int row);
    @(negedge clk);
    bus.redirect_valid  = v.rv;
    bus.redirect_pc     = v.rpc;
    bus.out_ready       = v.ordy;
    bus.imem_req_ready  = v.qrdy;
    bus.imem_resp_valid = v.rsv;
    bus.imem_resp_data  = v.rdata;
    bus.imem_resp_err   = v.rerr;
    #1;
    check("req_valid", row, {63'd0, bus.imem_req_valid}, {63'd0, v.e_qv});
    check("req_addr",  row, bus.imem_req_addr, v.e_addr);
    check("out_valid", row, {63'd0, bus.out_valid}, {63'd0, v.e_ov});
    check("pc_out",    row, bus.pc_out, v.e_pc);
    check("instr_out", row, {32'd0, bus.instr_out}, {32'd0, v.e_instr});
    check("exception", row, {48'd0, bus.exception_out}, {48'd0, v.e_exc});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();

    // Basic fetch, accept, then a 5-cycle decode stall.
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,             1, A,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h00A00093, 0,  0, A,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,             0, A,     1, A, 32'h00A00093, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,             1, A+4,   0, A, 32'h00A00093, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h00100113, 0,  0, A+4,   0, A, 32'h00A00093, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,           0, A+4,   1, A+4, 32'h00100113, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,             0, A+4,   1, A+4, 32'h00100113, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,             1, A+8,   0, A+4, 32'h00100113, 0));
    // Access fault at A+8.
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hDEADBEEF, 1,  0, A+8,   0, A+4, 32'h00100113, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             0, A+8,   1, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,             0, A+8,   1, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, A+12,  0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,             1, A+12,  0, A+8, 32'h13, 16'h0002));
    // Redirect in WAIT, stale response three cycles later.
    tbl.push_back(mk(1, A+64'h1000, 0, 0, 0, 0, 0,    0, A+12,  0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             0, A+64'h1000, 0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             0, A+64'h1000, 0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h11111111, 0,  0, A+64'h1000, 0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, A+64'h1000, 0, A+8, 32'h13, 16'h0002));
    // Redirect to a misaligned PC.
    tbl.push_back(mk(1, A+2, 0, 0, 0, 0, 0,           0, A+64'h1000, 0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,             0, A+2,   0, A+8, 32'h13, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             0, A+2,   1, A+2, 32'h13, 16'h0001));
    // Redirect and out_ready together in HOLD: redirect wins.
    tbl.push_back(mk(1, A+64'h2000, 1, 0, 0, 0, 0,    0, A+2,   1, A+2, 32'h13, 16'h0001));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,             1, A+64'h2000, 0, A+2, 32'h13, 16'h0001));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // Reset taken while in WAIT, then redirect coinciding with out_ready.
    do_reset();
    apply_row(mk(0, 0, 0, 1, 0, 0, 0,             1, A, 0, 0, 0, 0), 100);
    apply_row(mk(0, 0, 0, 0, 1, 32'h00200193, 0,  0, A, 0, 0, 0, 0), 101);
    apply_row(mk(1, A+64'h3000, 1, 0, 0, 0, 0,    0, A, 1, A, 32'h00200193, 0), 102);
    apply_row(mk(0, 0, 0, 1, 0, 0, 0,             1, A+64'h3000, 0, A, 32'h00200193, 0), 103);

    // Redirect with same-cycle response in WAIT, PC wrap, redirect with response in DROP.
    apply_row(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 32'h22222222, 0,
                 0, A+64'h3000, 0, A, 32'h00200193, 0), 200);
    apply_row(mk(0, 0, 0, 1, 0, 0, 0,
                 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, A, 32'h00200193, 0), 201);
    apply_row(mk(0, 0, 0, 0, 1, 32'h00300213, 0,
                 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, A, 32'h00200193, 0), 202);
    apply_row(mk(0, 0, 1, 0, 0, 0, 0,
                 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00300213, 0), 203);
    apply_row(mk(0, 0, 0, 1, 0, 0, 0,
                 1, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00300213, 0), 204);
    apply_row(mk(1, A+64'h4000, 0, 0, 0, 0, 0,
                 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00300213, 0), 205);
    apply_row(mk(1, A+64'h5000, 0, 0, 1, 32'h33333333, 0,
                 0, A+64'h4000, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00300213, 0), 206);
    apply_row(mk(0, 0, 0, 0, 0, 0, 0,
                 1, A+64'h5000, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00300213, 0), 207);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the fetch/decode pipeline register.
- Owns the architectural fetch PC and issues one instruction-memory request at a time, with at most one outstanding.
- Produces {pc, instr, exception} plus a valid flag toward decode, and holds its output until decode accepts it.
- Handles redirects from later stages (branch/trap) by flushing the in-flight fetch. Also raises misaligned-PC and access-fault exceptions.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word emitted alongside an exception (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  load new fetch PC, flush in-flight work
- redirect_pc  in  64  redirect target
- out_ready  in  1  decode accepts the output this cycle (drives pipeline-register enable)
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  request address (= fetch PC)
- imem_resp_valid  in  1  response valid (single cycle, always accepted)
- imem_resp_data  in  32  instruction word
- imem_resp_err  in  1  access fault on this response
- out_valid  out  1  output triple valid
- pc_out  out  64  PC of output instruction
- instr_out  out  32  instruction word
- exception_out  out  16  one-hot: bit0 = instr address misaligned, bit1 = instr access fault, others 0

Behaviour:
- State register with four states: REQ, WAIT, HOLD, DROP.
- Reset (also mid-operation):
  - state = REQ, pc = RESET_PC.
  - out_valid = 0, pc_out = 0, instr_out = 0, exception_out = 0.
  - Any outstanding memory response after reset is not tracked. The memory side is reset together with this block.
- imem_req_valid = (state==REQ) && !redirect_valid && (pc[1:0]==0). This is combinational.
- imem_req_addr = pc at all times.
- The memory side tolerates withdrawal of req_valid without a handshake; this occurs only on redirect.
- REQ:
  - If redirect_valid: pc <= redirect_pc, stay in REQ.
  - Else if pc[1:0]!=0: no request is issued. Load pc_out = pc, instr_out = NOP_INSTR, exception_out = 16'h0001, out_valid = 1, then go to HOLD.
  - Else on req_valid && req_ready: go to WAIT.
  - Else stay in REQ.
- WAIT:
  - If redirect_valid: pc <= redirect_pc. Go to REQ if imem_resp_valid is high in the same cycle (that response is discarded), otherwise go to DROP.
  - Else on imem_resp_valid: pc_out = pc, out_valid = 1, then go to HOLD.
    - If resp_err: instr_out = NOP_INSTR, exception_out = 16'h0002.
    - Otherwise: instr_out = resp_data, exception_out = 0.
- HOLD:
  - Output regs are frozen while out_valid=1.
  - If redirect_valid: pc <= redirect_pc, out_valid <= 0, go to REQ. Redirect wins over a simultaneous out_ready; the instruction is discarded.
  - Else on out_ready: out_valid <= 0, pc <= pc + 4 (64-bit, wraps modulo 2^64), go to REQ.
- DROP:
  - Waits for the stale response.
  - A redirect in DROP updates pc and stays in DROP.
  - On imem_resp_valid: discard the response, go to REQ. If a redirect arrives in the same cycle, still go to REQ with the new pc.
- out_valid is never 1 outside HOLD.
- Output fields are don't-care when out_valid=0 but retain their last value (no clearing except reset).
- out_ready while out_valid=0 is ignored.
- Latency and throughput:
  - Request handshake at cycle t, response at cycle t+k: out_valid rises at t+k+1.
  - Next request is issued the cycle after acceptance.
  - Peak throughput is 1 instruction per 3 cycles with a 1-cycle memory.
- A response arriving in REQ or HOLD is a protocol violation. It is ignored, and an assertion fires in simulation.

Test Plan:
- Reset then 1-cycle-latency memory returning 0x00A00093 at 0x80000000, out_ready=1 → request at 0x80000000; out_valid=1 with pc_out=0x80000000, instr_out=0x00A00093, exception_out=0; next request at 0x80000004.
- out_ready held 0 for 5 cycles after out_valid → outputs constant and imem_req_valid=0 throughout; out_ready=1 then triggers a request at pc+4 the following cycle.
- Redirect to 0x80001000 in WAIT with response 3 cycles later → DROP entered, stale response discarded, out_valid stays 0, next request at 0x80001000.
- Redirect to 0x80000002 → no memory request; out_valid=1, pc_out=0x80000002, instr_out=0x00000013, exception_out=0x0001.
- Response with imem_resp_err=1 at 0x80000008 → instr_out=0x00000013, exception_out=0x0002, pc_out=0x80000008.
- rst asserted during WAIT, then a redirect and out_ready coincide in HOLD → after reset pc=RESET_PC and out_valid=0; in the coincident cycle the redirect wins, out_valid drops, and the next request goes to redirect_pc.
